// File: rtl/bz_pkg.sv
// Shared definitions for the buzzer music player: note word layout,
// special field values and the sequencer state encoding.
package bz_pkg;

    // Note word layout: [11:8] duration in beats, [7:0] tone half-period units
    localparam int DUR_MSB  = 11;
    localparam int DUR_LSB  = 8;
    localparam int TONE_MSB = 7;
    localparam int TONE_LSB = 0;

    // A zero duration terminates the song; a zero tone is a rest
    localparam logic [3:0] END_MARKER = 4'd0;
    localparam logic [7:0] REST_TONE  = 8'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5
    } state_t;

endpackage

// File: rtl/bz_tone_gen.sv
// Square-wave generator: high on the first enabled cycle, toggles every
// half_period cycles, held low while disabled or for a zero half-period.
module bz_tone_gen #(
    parameter int HP_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            wave
);

    logic [HP_W-1:0] cnt;
    logic            phase;

    // Count the current half-period; re-arm to a high phase whenever disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == half_period - HP_W'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + HP_W'(1);
        end
    end

    assign wave = en && (half_period != '0) && phase;

endmodule

// File: rtl/bz_music_player.sv
// Buzzer music sequencer: walks the note ROM from address 0, plays each
// note as a square wave for its duration, separates notes with a silent
// gap and either stops or loops at the end-of-song marker.
module bz_music_player
    import bz_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 12,
    parameter int BEAT_CYCLES = 6250000,
    parameter int TONE_UNIT   = 1000,
    parameter int GAP_CYCLES  = 250000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  buzz_o,
    output logic                  busy,
    output logic                  done
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int HP_W   = 8 + $clog2(TONE_UNIT);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [3:0]            beats_left;
    logic [GAP_W-1:0]      gap_cnt;
    logic [HP_W-1:0]       half_period;

    logic [3:0] dur_in;
    logic [7:0] tone_in;
    logic       play_last;
    logic       gap_last;
    logic       addr_at_max;

    assign dur_in      = rom_data[DUR_MSB:DUR_LSB];
    assign tone_in     = rom_data[TONE_MSB:TONE_LSB];
    assign play_last   = (beat_cnt == BEAT_LAST) && (beats_left == 4'd1);
    assign gap_last    = (gap_cnt == GAP_LAST);
    assign addr_at_max = (addr == ADDR_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode and the done pulse; stop overrides everything
    always_comb begin
        next_state = state;
        done       = 1'b0;
        if (stop) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_FETCH;
                S_FETCH: next_state = S_LOAD;
                S_LOAD:  next_state = (dur_in == END_MARKER) ? S_END : S_PLAY;
                S_PLAY: begin
                    if (play_last) begin
                        if (GAP_CYCLES > 0) next_state = S_GAP;
                        else                next_state = addr_at_max ? S_END : S_FETCH;
                    end
                end
                S_GAP:   if (gap_last) next_state = addr_at_max ? S_END : S_FETCH;
                S_END: begin
                    if (loop_en) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_IDLE;
                        done       = 1'b1;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Address advances into each FETCH; restarts at 0 from IDLE/END or on stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (stop) begin
            addr <= '0;
        end else if (next_state == S_FETCH) begin
            addr <= (state == S_PLAY || state == S_GAP) ? addr + ADDR_WIDTH'(1) : '0;
        end
    end

    // Note timing: beat/duration counters, tone period and gap counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt    <= '0;
            beats_left  <= '0;
            half_period <= '0;
            gap_cnt     <= '0;
        end else begin
            if (state == S_LOAD) begin
                beat_cnt    <= '0;
                beats_left  <= dur_in;
                half_period <= HP_W'(tone_in) * HP_W'(TONE_UNIT);
            end else if (state == S_PLAY) begin
                if (beat_cnt == BEAT_LAST) begin
                    beat_cnt   <= '0;
                    beats_left <= beats_left - 4'd1;
                end else begin
                    beat_cnt   <= beat_cnt + BEAT_W'(1);
                end
            end
            if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else                gap_cnt <= '0;
        end
    end

    bz_tone_gen #(.HP_W(HP_W)) u_tone (
        .clk         (clk),
        .rst         (rst),
        .en          (state == S_PLAY),
        .half_period (half_period),
        .wave        (buzz_o)
    );

    assign rom_en   = (state == S_FETCH);
    assign rom_addr = rom_en ? addr : '0;
    assign busy     = (state != S_IDLE);

endmodule

// File: doc/bz_music_player.md
Name: bz_music_player

Overview:
- Sequencer directly downstream of the buzzer music ROM.
- Walks the ROM from address 0 and decodes each 12-bit note word into a tone half-period and a duration.
- Drives a square wave on the buzzer pin until an end-of-song marker, then either stops or loops.
- Started and stopped by single-cycle pulses from the game control logic.

Parameters:
- ADDR_WIDTH, 11: ROM address width.
- DATA_WIDTH, 12: ROM word width; note format is fixed to 12 bits.
- BEAT_CYCLES, 6250000: clk cycles per duration unit (125 ms at 50 MHz).
- TONE_UNIT, 1000: clk cycles per tone-field LSB (20 us at 50 MHz).
- GAP_CYCLES, 250000: silent articulation gap after each note word (5 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begin song at address 0 (ignored unless IDLE)
- stop  in  1  single-cycle pulse; abort immediately (wins over start)
- loop_en  in  1  sampled at end marker: 1 = restart at address 0
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  DATA_WIDTH  ROM registered read data, valid one cycle after rom_en
- buzz_o  out  1  square wave to buzzer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the song ends without looping

Behaviour:
- Note word fields:
  - [11:8] dur: beats 1..15; dur=0 is the end-of-song marker, and its tone field is ignored.
  - [7:0] tone: half-period = tone*TONE_UNIT cycles; tone=0 is a rest.
- Reset values: rom_en=0, rom_addr=0, buzz_o=0, busy=0, done=0, state IDLE, all counters 0.
- States are IDLE, FETCH, LOAD, PLAY, GAP, END.
- IDLE:
  - start=1 → FETCH with addr=0.
  - buzz_o=0.
- FETCH:
  - Lasts one cycle; rom_en=1 and rom_addr=addr in that cycle only.
  - Always → LOAD.
- LOAD:
  - Lasts one cycle; latches rom_data.
  - dur=0 → END.
  - Otherwise: beat counter=0, remaining beats=dur, half-period counter=0 → PLAY.
- PLAY:
  - Lasts exactly dur*BEAT_CYCLES cycles.
  - tone≠0: buzz_o=1 on the first PLAY cycle, then toggles every tone*TONE_UNIT cycles.
  - tone=0: buzz_o=0 throughout.
  - On the last PLAY cycle → GAP.
- GAP:
  - GAP_CYCLES cycles with buzz_o=0.
  - addr = max (2^ADDR_WIDTH-1) → END; no wrap-through.
  - Otherwise addr+1 → FETCH.
- END:
  - Lasts one cycle, buzz_o=0.
  - loop_en=1 → addr=0, FETCH; no done pulse.
  - loop_en=0 → done=1 for this cycle → IDLE.
- Latency: start at edge n gives rom_en at cycle n+1 and the first PLAY cycle at n+3.
- stop=1 in any state: next state IDLE, buzz_o=0 on the next cycle, addr cleared to 0, no done pulse.
- start while busy is ignored; start and stop in the same cycle → stop wins.
- GAP_CYCLES=0 is legal: GAP lasts zero cycles, so PLAY goes directly to FETCH.
- Async rst mid-note: outputs return to reset values immediately; no resume.
- Arithmetic widths:
  - Beat counter: clog2(BEAT_CYCLES).
  - Half-period counter: 8+clog2(TONE_UNIT), compared against tone*TONE_UNIT registered at LOAD.
  - Gap counter: clog2(GAP_CYCLES+1).
  - No counter may overflow at any parameter maxima.

Decomposition:
- Shared package/header bz_pkg:
  - Field positions DUR_MSB/DUR_LSB/TONE_MSB/TONE_LSB.
  - END_MARKER (dur=0) and REST_TONE (0).
  - State encoding localparams.
- One sub-module bz_tone_gen:
  - Inputs: clk, rst, en, half_period.
  - Output: wave, which is 1 on the first enabled cycle, toggles every half_period cycles, and forces 0 when en=0 or half_period=0.

Test Plan:
Bench parameters: BEAT_CYCLES=20, TONE_UNIT=2, GAP_CYCLES=4.
1. Reset with rst high for 3 cycles → buzz_o=0, busy=0, rom_en=0, rom_addr=0, done=0; hold rst high during start → no activity.
2. ROM[0]=0x203, ROM[1]=0x000, pulse start:
   - rom_en=1 with rom_addr=0 one cycle later.
   - PLAY lasts 40 cycles with buzz_o toggling every 6 cycles, starting high.
   - 4 low gap cycles, then fetch addr 1.
   - done pulses once, then busy=0.
3. ROM[0]=0x100, ROM[1]=0x000 → buzz_o stays 0 for 20 PLAY cycles while busy=1; done follows the gap.
4. ROM[0..1]=0x101,0x000, loop_en=1 → after END, rom_addr returns to 0; no done for 3 loops. Clear loop_en → done after the next END.
5. Stop mid-PLAY of 0x305 → buzz_o=0 and busy=0 next cycle, no done. Start issued while busy before the stop is ignored. A fresh start fetches addr 0 again.
6. ADDR_WIDTH=2, all four words 0x101 → plays addrs 0..3, then done with loop_en=0; with loop_en=1 the next fetch is addr 0.
